sub12_seq: RTL

Sequential 12-bit subtractor computing diff = a - b - bin, one 4-bit digit per clock, LSB digit first.
Each digit uses a borrow-lookahead cell; the borrow is registered between digits.
It is the inverse-direction companion to the team's 12-bit carry-lookahead adder.
It sits behind a start/done handshake for multi-cycle datapaths where a full-width lookahead would limit timing.

---
 rtl/sub12_pkg.sv | 23 ++
 rtl/sub12_seq_blu4.sv | 41 ++++
 rtl/sub12_seq.sv | 154 +++++++++++++++
 3 files changed

// File: rtl/sub12_pkg.sv
// Shared types, defaults and sizing helpers for the sequential subtractor.
package sub12_pkg;

  localparam int unsigned WIDTH_DEF = 12;
  localparam int unsigned DIGIT_DEF = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  // Number of digits processed per operation.
  function automatic int unsigned ndig_f(input int unsigned width, input int unsigned digit);
    return width / digit;
  endfunction

  // Width of the digit index; at least one bit so the counter always exists.
  function automatic int unsigned idx_w_f(input int unsigned ndig);
    return (ndig > 1) ? $clog2(ndig) : 1;
  endfunction

endpackage

// File: rtl/sub12_seq_blu4.sv
// Combinational DIGIT-bit borrow-lookahead cell: d = x - y - bi, bo = borrow-out.
module blu4 #(
  parameter int unsigned DIGIT = 4
) (
  input  logic [DIGIT-1:0] x,
  input  logic [DIGIT-1:0] y,
  input  logic             bi,
  output logic [DIGIT-1:0] d,
  output logic             bo
);

  logic [DIGIT-1:0] g;
  logic [DIGIT-1:0] p;
  logic [DIGIT:0]   bw;

  // Generate: x=0,y=1 always borrows; propagate: x==y passes the incoming borrow.
  assign g = ~x & y;
  assign p = ~(x ^ y);

  // Flattened lookahead: each borrow is a sum of generate terms gated by propagate runs.
  always_comb begin : lookahead
    logic acc;
    logic run;
    bw    = '0;
    bw[0] = bi;
    for (int unsigned i = 0; i < DIGIT; i++) begin
      acc = 1'b0;
      run = 1'b1;
      for (int j = int'(i); j >= 0; j--) begin
        acc = acc | (run & g[j]);
        run = run & p[j];
      end
      bw[i+1] = acc | (run & bi);
    end
  end

  // Difference bits use the borrow into each position.
  assign d  = x ^ y ^ bw[DIGIT-1:0];
  assign bo = bw[DIGIT];

endmodule

// File: rtl/sub12_seq.sv
// Sequential subtractor: diff = a - b - bin, one DIGIT-wide digit per clock, LSB first.
// Optional: define SUB12_SIGNED_OVF_EN to add the registered two's-complement ovf output.
module sub12_seq
  import sub12_pkg::*;
#(
  parameter int unsigned WIDTH = WIDTH_DEF,
  parameter int unsigned DIGIT = DIGIT_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
`ifdef SUB12_SIGNED_OVF_EN
  output logic             ovf,
`endif
  output logic             bout
);

  localparam int unsigned NDIG = ndig_f(WIDTH, DIGIT);
  localparam int unsigned KW   = idx_w_f(NDIG);

  state_e           state_q, state_d;
  logic [KW-1:0]    k_q, k_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic             brw_q, brw_d;
  logic [WIDTH-1:0] diff_q, diff_d;
  logic             bout_q, bout_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
`ifdef SUB12_SIGNED_OVF_EN
  logic             ovf_q, ovf_d;
`endif

  logic [DIGIT-1:0] cell_x, cell_y, cell_d;
  logic             cell_bo;
  logic             last_c;
  logic             accept_c;

  // Select the operand digit addressed by k for the single shared cell.
  always_comb begin : digit_mux
    cell_x = '0;
    cell_y = '0;
    for (int unsigned i = 0; i < NDIG; i++) begin
      if (k_q == KW'(i)) begin
        cell_x = a_q[i*DIGIT +: DIGIT];
        cell_y = b_q[i*DIGIT +: DIGIT];
      end
    end
  end

  blu4 #(.DIGIT(DIGIT)) u_blu4 (
    .x  (cell_x),
    .y  (cell_y),
    .bi (brw_q),
    .d  (cell_d),
    .bo (cell_bo)
  );

  assign last_c   = (k_q == KW'(NDIG - 1));
  assign accept_c = start && ((state_q == IDLE) || (state_q == DONE));

  // Next-state and datapath update; capture on accept, one digit per RUN cycle.
  always_comb begin : fsm_next
    state_d = state_q;
    k_d     = k_q;
    a_d     = a_q;
    b_d     = b_q;
    brw_d   = brw_q;
    diff_d  = diff_q;
    bout_d  = bout_q;
`ifdef SUB12_SIGNED_OVF_EN
    ovf_d   = ovf_q;
`endif

    unique case (state_q)
      IDLE: ;
      RUN: begin
        for (int unsigned i = 0; i < NDIG; i++) begin
          if (k_q == KW'(i)) diff_d[i*DIGIT +: DIGIT] = cell_d;
        end
        brw_d = cell_bo;
        if (last_c) begin
          state_d = DONE;
          k_d     = '0;
          bout_d  = cell_bo;
`ifdef SUB12_SIGNED_OVF_EN
          ovf_d   = (a_q[WIDTH-1] != b_q[WIDTH-1]) && (cell_d[DIGIT-1] != a_q[WIDTH-1]);
`endif
        end else begin
          k_d = k_q + KW'(1);
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    if (accept_c) begin
      state_d = RUN;
      a_d     = a;
      b_d     = b;
      brw_d   = bin;
      k_d     = '0;
    end

    busy_d = (state_d == RUN);
    done_d = (state_d == DONE);
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      k_q     <= '0;
      a_q     <= '0;
      b_q     <= '0;
      brw_q   <= 1'b0;
      diff_q  <= '0;
      bout_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
`ifdef SUB12_SIGNED_OVF_EN
      ovf_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      k_q     <= k_d;
      a_q     <= a_d;
      b_q     <= b_d;
      brw_q   <= brw_d;
      diff_q  <= diff_d;
      bout_q  <= bout_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
`ifdef SUB12_SIGNED_OVF_EN
      ovf_q   <= ovf_d;
`endif
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign diff = diff_q;
  assign bout = bout_q;
`ifdef SUB12_SIGNED_OVF_EN
  assign ovf  = ovf_q;
`endif

endmodule
